fifo_wr_arbiter: RTL

Round-robin write-port arbiter that shares the single write port of the 16-deep, 8-bit synchronous FIFO among several producers. Each producer offers data on a valid/ready handshake; the arbiter grants one producer at a time for a bounded burst, muxes its data onto the FIFO write port, and enforces back-pressure from the FIFO `full` flag. It sits directly in front of the FIFO write side; the FIFO read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// +----------------------------------------------------------------------------+
// | fifo_wr_arbiter                                                            |
// | Round-robin, burst-bounded arbiter sharing one FIFO write port.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         fifo_wr_en,
    output logic [DATA_W-1:0]            fifo_data,
    input  logic                         fifo_full,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BCW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t           state_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   grant_id_q;
    logic [BCW-1:0]   beat_cnt_q;
    logic             busy_q;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [IDW-1:0]   cand;
    logic             g_valid;
    logic             xfer;
    logic             grant_done;
    logic [IDW-1:0]   rr_ptr_d;
    logic [BCW-1:0]   beat_cnt_d;
    logic [DATA_W-1:0] g_data;

    // Scan downward so the lowest offset from rr_ptr is the one that sticks.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        g_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == IDW'(i)) begin
                g_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign g_valid    = req_valid[grant_id_q];
    assign xfer       = (state_q == S_GRANT) && g_valid && !fifo_full;
    assign grant_done = !g_valid ||
                        (xfer && (req_last[grant_id_q] ||
                                  (beat_cnt_q == BCW'(MAX_BURST - 1))));
    assign rr_ptr_d   = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);
    assign beat_cnt_d = beat_cnt_q + BCW'(1);

    always_comb begin
        req_ready = '0;
        if (state_q == S_GRANT && !fifo_full) begin
            req_ready[grant_id_q] = 1'b1;
        end
    end

    assign fifo_wr_en = xfer;
    assign fifo_data  = (state_q == S_GRANT) ? g_data : '0;
    assign grant_id   = grant_id_q;
    assign busy       = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        state_q    <= S_GRANT;
                        grant_id_q <= win_idx;
                        beat_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                S_GRANT: begin
                    if (grant_done) begin
                        state_q  <= S_IDLE;
                        rr_ptr_q <= rr_ptr_d;
                        busy_q   <= 1'b0;
                    end else if (xfer) begin
                        beat_cnt_q <= beat_cnt_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
